// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC LVDS frame alignment controller.
package adc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SRST,
        SETTLE,
        CMP,
        SLIP,
        VERIFY,
        LOCKED,
        RETRY,
        FAIL
    } align_state_t;

    localparam logic [7:0] ADC_FRAME_PATTERN_DEF = 8'hF0;
    localparam int         TMR_W                 = 8;

    // Down-counter preload for a phase of n cycles when k of them are already spent.
    function automatic logic [TMR_W-1:0] tmr_preload(input int n, input int k);
        return (n > k) ? TMR_W'(n - k) : '0;
    endfunction

endpackage

// File: rtl/adc_align_timer.sv
// Loadable down-counter; done is high while the count is zero.
module adc_align_timer
    import adc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/adc_align_ctrl.sv
// ISERDES frame-word training sequencer (reset, bitslip search, verify, lock monitor, retry).
// Optional ADC_ALIGN_STATS_EN adds loss_cnt, a saturating count of lock losses.
module adc_align_ctrl
    import adc_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = ADC_FRAME_PATTERN_DEF,
    parameter int         RST_CYCLES    = 8,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MAX_SLIPS     = 8,
    parameter int         VERIFY_WORDS  = 16,
    parameter int         LOSS_WORDS    = 4,
    parameter int         MAX_RETRIES   = 3
) (
    input  logic       CLKDIV,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] frm_data,
    output logic       serdes_rst,
    output logic       bitslip,
    output logic       adc_en,
    output logic       aligned,
    output logic       fail,
    output logic [3:0] slip_cnt,
    output logic [1:0] retry_cnt
`ifdef ADC_ALIGN_STATS_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    align_state_t     state_q, state_d;
    logic [3:0]       slip_cnt_q, slip_cnt_d;
    logic [1:0]       retry_cnt_q, retry_cnt_d;
    logic [3:0]       mis_cnt_q, mis_cnt_d;
    logic             serdes_rst_q, bitslip_q, adc_en_q, aligned_q, fail_q;
    logic             tmr_load, tmr_dec, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic             match;

    assign match = (frm_data == FRAME_PATTERN);

    adc_align_timer u_timer (
        .clk      (CLKDIV),
        .rst      (RST),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        slip_cnt_d  = slip_cnt_q;
        retry_cnt_d = retry_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = '0;
        if (!start) begin
            state_d     = IDLE;
            slip_cnt_d  = '0;
            retry_cnt_d = '0;
            mis_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    slip_cnt_d  = '0;
                    retry_cnt_d = '0;
                    mis_cnt_d   = '0;
                    state_d     = SRST;
                    tmr_load    = 1'b1;
                    tmr_val     = tmr_preload(RST_CYCLES, 1);
                end
                SRST: begin
                    if (tmr_done) begin
                        state_d  = SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = tmr_preload(SETTLE_CYCLES, 1);
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                SETTLE: begin
                    if (tmr_done) begin
                        state_d = CMP;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                CMP: begin
                    if (match) begin
                        // The word sampled here is the first of the verify run.
                        state_d   = (VERIFY_WORDS <= 1) ? LOCKED : VERIFY;
                        mis_cnt_d = '0;
                        tmr_load  = 1'b1;
                        tmr_val   = tmr_preload(VERIFY_WORDS, 2);
                    end else if (slip_cnt_q < 4'(MAX_SLIPS)) begin
                        state_d = SLIP;
                    end else begin
                        state_d = RETRY;
                    end
                end
                SLIP: begin
                    if (slip_cnt_q != 4'hF) begin
                        slip_cnt_d = slip_cnt_q + 4'd1;
                    end
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = tmr_preload(SETTLE_CYCLES, 1);
                end
                VERIFY: begin
                    if (match) begin
                        if (tmr_done) begin
                            state_d = LOCKED;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end else if (slip_cnt_q < 4'(MAX_SLIPS)) begin
                        state_d = SLIP;
                    end else begin
                        state_d = RETRY;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        mis_cnt_d = '0;
                    end else if (mis_cnt_q >= 4'(LOSS_WORDS - 1)) begin
                        mis_cnt_d = '0;
                        state_d   = RETRY;
                    end else begin
                        mis_cnt_d = mis_cnt_q + 4'd1;
                    end
                end
                RETRY: begin
                    if (retry_cnt_q < 2'(MAX_RETRIES)) begin
                        retry_cnt_d = retry_cnt_q + 2'd1;
                        slip_cnt_d  = '0;
                        state_d     = SRST;
                        tmr_load    = 1'b1;
                        tmr_val     = tmr_preload(RST_CYCLES, 1);
                    end else begin
                        state_d = FAIL;
                    end
                end
                FAIL: state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so each one is a flop aligned with state_q.
    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            slip_cnt_q   <= '0;
            retry_cnt_q  <= '0;
            mis_cnt_q    <= '0;
            serdes_rst_q <= 1'b0;
            bitslip_q    <= 1'b0;
            adc_en_q     <= 1'b0;
            aligned_q    <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slip_cnt_q   <= slip_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
            serdes_rst_q <= (state_d == SRST);
            bitslip_q    <= (state_d == SLIP);
            adc_en_q     <= (state_d == SETTLE) || (state_d == CMP) || (state_d == SLIP) ||
                            (state_d == VERIFY) || (state_d == LOCKED);
            aligned_q    <= (state_d == LOCKED);
            fail_q       <= (state_d == FAIL);
        end
    end

    assign serdes_rst = serdes_rst_q;
    assign bitslip    = bitslip_q;
    assign adc_en     = adc_en_q;
    assign aligned    = aligned_q;
    assign fail       = fail_q;
    assign slip_cnt   = slip_cnt_q;
    assign retry_cnt  = retry_cnt_q;

`ifdef ADC_ALIGN_STATS_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == LOCKED) && (state_d == RETRY) && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLKDIV or posedge RST) begin
        if (RST) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Testbench for adc_align_ctrl: ISERDES rotation model plus scenario tasks with inline checks.
module tb_adc_align_ctrl;

    localparam int         RST_CYCLES    = 8;
    localparam int         SETTLE_CYCLES = 3;
    localparam int         MAX_SLIPS     = 8;
    localparam int         VERIFY_WORDS  = 16;
    localparam int         LOSS_WORDS    = 4;
    localparam int         MAX_RETRIES   = 3;
    localparam logic [7:0] PAT           = 8'hF0;

    // Timing derived from the state rules: a failed compare costs CMP + SLIP + SETTLE.
    localparam int SLIP_COST     = SETTLE_CYCLES + 2;
    localparam int LOCK_EDGES    = 1 + RST_CYCLES + SETTLE_CYCLES + VERIFY_WORDS;
    localparam int ATTEMPT_EDGES = RST_CYCLES + (MAX_SLIPS + 1) * (SETTLE_CYCLES + 1) + MAX_SLIPS + 1;
    localparam int FAIL_EDGES    = 1 + (MAX_RETRIES + 1) * ATTEMPT_EDGES;

    logic       CLKDIV = 1'b0;
    logic       RST    = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] frm_data;
    logic       serdes_rst, bitslip, adc_en, aligned, fail;
    logic [3:0] slip_cnt;
    logic [1:0] retry_cnt;
`ifdef ADC_ALIGN_STATS_EN
    logic [7:0] loss_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    adc_align_ctrl dut (
        .CLKDIV     (CLKDIV),
        .RST        (RST),
        .start      (start),
        .frm_data   (frm_data),
        .serdes_rst (serdes_rst),
        .bitslip    (bitslip),
        .adc_en     (adc_en),
        .aligned    (aligned),
        .fail       (fail),
        .slip_cnt   (slip_cnt),
        .retry_cnt  (retry_cnt)
`ifdef ADC_ALIGN_STATS_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 CLKDIV = ~CLKDIV;

    // ISERDES model: the frame word is the pattern rotated left by offset; each bitslip adds one.
    int         offset_init = 0;
    int         offset      = 0;
    bit         use_model   = 1'b1;
    bit         mon_clr     = 1'b0;
    logic [7:0] frm_drv     = PAT;
    int         pulse_cnt   = 0;
    int         srst_rise   = 0;
    int         adj_viol    = 0;
    int         cyc         = 0;
    int         last_pulse  = -1;
    int         min_gap     = 1000;
    int         max_gap     = 0;
    logic       prev_bs     = 1'b0;
    logic       prev_srst   = 1'b0;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

    function automatic logic [7:0] rand_miss();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == PAT) v = ~PAT;
        return v;
    endfunction

    always_comb frm_data = use_model ? rotl(PAT, offset) : frm_drv;

    always @(posedge CLKDIV) begin
        cyc       <= cyc + 1;
        prev_bs   <= bitslip;
        prev_srst <= serdes_rst;
        if (mon_clr) begin
            offset     <= offset_init;
            pulse_cnt  <= 0;
            srst_rise  <= 0;
            adj_viol   <= 0;
            last_pulse <= -1;
            min_gap    <= 1000;
            max_gap    <= 0;
        end else begin
            if (bitslip) begin
                offset     <= offset + 1;
                pulse_cnt  <= pulse_cnt + 1;
                last_pulse <= cyc;
                if (last_pulse >= 0) begin
                    if (cyc - last_pulse < min_gap) min_gap <= cyc - last_pulse;
                    if (cyc - last_pulse > max_gap) max_gap <= cyc - last_pulse;
                end
                if (prev_bs || serdes_rst) adj_viol <= adj_viol + 1;
            end
            if (serdes_rst && !prev_srst) srst_rise <= srst_rise + 1;
        end
    end

    task automatic step();
        @(posedge CLKDIV);
        #1;
    endtask

    task automatic go_idle(input int k);
        start       = 1'b0;
        use_model   = 1'b1;
        offset_init = k;
        mon_clr     = 1'b1;
        step();
        mon_clr     = 1'b0;
        step();
    endtask

    task automatic wait_for_aligned(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!aligned && n < bound);
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        start = 1'b0;
        step();
        step();
        n_vec++; if (serdes_rst !== 1'b0) begin n_err++; $display("FAIL reset_serdes_rst: got %b want 0", serdes_rst); end
        n_vec++; if (bitslip !== 1'b0)    begin n_err++; $display("FAIL reset_bitslip: got %b want 0", bitslip); end
        n_vec++; if (adc_en !== 1'b0)     begin n_err++; $display("FAIL reset_adc_en: got %b want 0", adc_en); end
        n_vec++; if (aligned !== 1'b0)    begin n_err++; $display("FAIL reset_aligned: got %b want 0", aligned); end
        n_vec++; if (fail !== 1'b0)       begin n_err++; $display("FAIL reset_fail: got %b want 0", fail); end
        n_vec++; if (slip_cnt !== 4'd0)   begin n_err++; $display("FAIL reset_slip_cnt: got %0d want 0", slip_cnt); end
        n_vec++; if (retry_cnt !== 2'd0)  begin n_err++; $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_aligned_start();
        int n;
        go_idle(0);
        start = 1'b1;
        wait_for_aligned(200, n);
        n_vec++; if (n != LOCK_EDGES)     begin n_err++; $display("FAIL direct_lock_time: got %0d want %0d", n, LOCK_EDGES); end
        n_vec++; if (aligned !== 1'b1)    begin n_err++; $display("FAIL direct_aligned: got %b want 1", aligned); end
        n_vec++; if (pulse_cnt != 0)      begin n_err++; $display("FAIL direct_pulses: got %0d want 0", pulse_cnt); end
        n_vec++; if (slip_cnt !== 4'd0)   begin n_err++; $display("FAIL direct_slip_cnt: got %0d want 0", slip_cnt); end
        n_vec++; if (adc_en !== 1'b1)     begin n_err++; $display("FAIL direct_adc_en: got %b want 1", adc_en); end
        n_vec++; if (retry_cnt !== 2'd0)  begin n_err++; $display("FAIL direct_retry_cnt: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_bitslip();
        for (int i = 0; i < 5; i++) begin
            int k, slips, n;
            k     = (i == 0) ? 5 : int'($urandom_range(0, 7));
            slips = (8 - k) % 8;
            go_idle(k);
            start = 1'b1;
            wait_for_aligned(400, n);
            n_vec++; if (n != LOCK_EDGES + SLIP_COST * slips) begin n_err++; $display("FAIL slip_lock_time k=%0d: got %0d want %0d", k, n, LOCK_EDGES + SLIP_COST * slips); end
            n_vec++; if (pulse_cnt != slips)       begin n_err++; $display("FAIL slip_pulses k=%0d: got %0d want %0d", k, pulse_cnt, slips); end
            n_vec++; if (slip_cnt !== 4'(slips))   begin n_err++; $display("FAIL slip_cnt k=%0d: got %0d want %0d", k, slip_cnt, slips); end
            n_vec++; if (adj_viol != 0)            begin n_err++; $display("FAIL slip_adjacent k=%0d: got %0d want 0", k, adj_viol); end
            if (slips > 1) begin
                n_vec++; if (min_gap != SLIP_COST || max_gap != SLIP_COST) begin n_err++; $display("FAIL slip_spacing k=%0d: got %0d..%0d want %0d", k, min_gap, max_gap, SLIP_COST); end
            end
        end
    endtask

    task automatic test_fail();
        int n;
        go_idle(0);
        use_model = 1'b0;
        start     = 1'b1;
        n = 0;
        do begin
            frm_drv = rand_miss();
            step();
            n++;
        end while (!fail && n < 1000);
        n_vec++; if (n != FAIL_EDGES)   begin n_err++; $display("FAIL fail_time: got %0d want %0d", n, FAIL_EDGES); end
        n_vec++; if (pulse_cnt != (MAX_RETRIES + 1) * MAX_SLIPS) begin n_err++; $display("FAIL fail_pulses: got %0d want %0d", pulse_cnt, (MAX_RETRIES + 1) * MAX_SLIPS); end
        n_vec++; if (srst_rise != MAX_RETRIES + 1) begin n_err++; $display("FAIL fail_srst_phases: got %0d want %0d", srst_rise, MAX_RETRIES + 1); end
        n_vec++; if (retry_cnt !== 2'(MAX_RETRIES)) begin n_err++; $display("FAIL fail_retry_cnt: got %0d want %0d", retry_cnt, MAX_RETRIES); end
        n_vec++; if (adc_en !== 1'b0)   begin n_err++; $display("FAIL fail_adc_en: got %b want 0", adc_en); end
        n_vec++; if (aligned !== 1'b0)  begin n_err++; $display("FAIL fail_aligned: got %b want 0", aligned); end
        n_vec++; if (adj_viol != 0)     begin n_err++; $display("FAIL fail_adjacent: got %0d want 0", adj_viol); end
        repeat (5) begin
            frm_drv = rand_miss();
            step();
        end
        n_vec++; if (fail !== 1'b1)     begin n_err++; $display("FAIL fail_hold: got %b want 1", fail); end
        start = 1'b0;
        step();
        n_vec++; if (fail !== 1'b0)     begin n_err++; $display("FAIL fail_release: got %b want 0", fail); end
        n_vec++; if (retry_cnt !== 2'd0) begin n_err++; $display("FAIL fail_release_retry: got %0d want 0", retry_cnt); end
        use_model = 1'b1;
    endtask

    task automatic test_lock_loss();
        int n, run;
        go_idle(0);
        start = 1'b1;
        wait_for_aligned(200, n);
        n_vec++; if (aligned !== 1'b1) begin n_err++; $display("FAIL loss_initial_lock: got %b want 1", aligned); end
        frm_drv   = PAT;
        use_model = 1'b0;
        run = 0;
        for (int r = 0; r < 24; r++) begin
            int len;
            len = int'($urandom_range(0, LOSS_WORDS - 1));
            for (int j = 0; j < len; j++) begin
                frm_drv = rand_miss();
                step();
                run++;
                n_vec++; if (aligned !== (run < LOSS_WORDS)) begin n_err++; $display("FAIL loss_short_run r=%0d: got %b want %b", r, aligned, run < LOSS_WORDS); end
            end
            frm_drv = PAT;
            step();
            run = 0;
            n_vec++; if (aligned !== 1'b1) begin n_err++; $display("FAIL loss_match r=%0d: got %b want 1", r, aligned); end
        end
        for (int j = 1; j <= LOSS_WORDS; j++) begin
            frm_drv = rand_miss();
            step();
            n_vec++; if (aligned !== (j < LOSS_WORDS)) begin n_err++; $display("FAIL loss_run j=%0d: got %b want %b", j, aligned, j < LOSS_WORDS); end
        end
        step();
        n_vec++; if (serdes_rst !== 1'b1) begin n_err++; $display("FAIL loss_serdes_rst: got %b want 1", serdes_rst); end
        n_vec++; if (retry_cnt !== 2'd1)  begin n_err++; $display("FAIL loss_retry_cnt: got %0d want 1", retry_cnt); end
        use_model = 1'b1;
        wait_for_aligned(200, n);
        n_vec++; if (n != LOCK_EDGES - 1) begin n_err++; $display("FAIL loss_relock_time: got %0d want %0d", n, LOCK_EDGES - 1); end
        n_vec++; if (retry_cnt !== 2'd1)  begin n_err++; $display("FAIL loss_retry_kept: got %0d want 1", retry_cnt); end
    endtask

    task automatic test_rst_mid_slip();
        int n;
        go_idle(5);
        start = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!bitslip && n < 100);
        n_vec++; if (bitslip !== 1'b1) begin n_err++; $display("FAIL rst_slip_reached: got %b want 1", bitslip); end
        #2 RST = 1'b1;
        #1;
        n_vec++; if ({serdes_rst, bitslip, adc_en, aligned, fail} !== 5'b0) begin n_err++; $display("FAIL rst_async_flags: got %b want 00000", {serdes_rst, bitslip, adc_en, aligned, fail}); end
        n_vec++; if ({slip_cnt, retry_cnt} !== 6'd0) begin n_err++; $display("FAIL rst_async_counts: got %0h want 0", {slip_cnt, retry_cnt}); end
        start = 1'b0;
        step();
        RST = 1'b0;
        go_idle(0);
        start = 1'b1;
        wait_for_aligned(200, n);
        n_vec++; if (n != LOCK_EDGES) begin n_err++; $display("FAIL rst_relock_time: got %0d want %0d", n, LOCK_EDGES); end
        n_vec++; if (pulse_cnt != 0)  begin n_err++; $display("FAIL rst_relock_pulses: got %0d want 0", pulse_cnt); end
    endtask

    task automatic test_start_drop();
        int n;
        go_idle(0);
        start = 1'b1;
        repeat (20) step();
        n_vec++; if ({adc_en, aligned} !== 2'b10) begin n_err++; $display("FAIL drop_in_verify: got %b want 10", {adc_en, aligned}); end
        start = 1'b0;
        step();
        n_vec++; if ({serdes_rst, bitslip, adc_en, aligned, fail} !== 5'b0) begin n_err++; $display("FAIL drop_flags: got %b want 00000", {serdes_rst, bitslip, adc_en, aligned, fail}); end
        n_vec++; if ({slip_cnt, retry_cnt} !== 6'd0) begin n_err++; $display("FAIL drop_counts: got %0h want 0", {slip_cnt, retry_cnt}); end
        start = 1'b1;
        wait_for_aligned(200, n);
        n_vec++; if (n != LOCK_EDGES) begin n_err++; $display("FAIL drop_relock_time: got %0d want %0d", n, LOCK_EDGES); end
    endtask

`ifdef ADC_ALIGN_STATS_EN
    task automatic test_stats();
        int n, losses;
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_vec++; if (loss_cnt !== 8'd0) begin n_err++; $display("FAIL stats_reset: got %0d want 0", loss_cnt); end
        losses = 0;
        for (int i = 0; i < 300; i++) begin
            go_idle(0);
            start = 1'b1;
            wait_for_aligned(200, n);
            use_model = 1'b0;
            repeat (LOSS_WORDS) begin
                frm_drv = rand_miss();
                step();
            end
            use_model = 1'b1;
            losses = (losses < 255) ? losses + 1 : 255;
            if (i == 1 || i == 254 || i == 299) begin
                n_vec++; if (loss_cnt !== 8'(losses)) begin n_err++; $display("FAIL stats_loss_cnt i=%0d: got %0d want %0d", i, loss_cnt, losses); end
            end
        end
        start = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_aligned_start();
        test_bitslip();
        test_fail();
        test_lock_loss();
        test_rst_mid_slip();
        test_start_drop();
`ifdef ADC_ALIGN_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
